// File: rtl/hazard_control_unit.sv
// Pipeline stall/flush/forward sequencing and NZVC flag ownership
// for the five-stage CPU; tracks EX/MEM destinations internally.
module hazard_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rn,
  input  logic [4:0] id_rm,
  input  logic       id_use_rn,
  input  logic       id_use_rm,
  input  logic [4:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       id_flag_enable,
  input  logic       id_is_cbz,
  input  logic       id_brtaken,
  input  logic       ex_negativef,
  input  logic       ex_overflowf,
  input  logic       ex_zerof,
  input  logic       ex_carryf,
  output logic       pc_we,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       flag_n,
  output logic       flag_v,
  output logic       flag_z,
  output logic       flag_c
);

  localparam logic [4:0] XZR = 5'd31;

  logic [4:0] ex_rd;
  logic       ex_regwrite;
  logic       ex_memread;
  logic       ex_flag_enable;
  logic [4:0] mem_rd;
  logic       mem_regwrite;
  logic [1:0] fwd_a_q;
  logic [1:0] fwd_b_q;
  logic [3:0] nzvc;

  logic       rn_ex;
  logic       rm_ex;
  logic       rn_mem;
  logic       rm_mem;
  logic       load_use;
  logic       cbz_stall;
  logic       stall;
  logic [1:0] fwd_a_d;
  logic [1:0] fwd_b_d;
  logic [3:0] live;

  assign rn_ex  = ex_regwrite && (ex_rd == id_rn) && (id_rn != XZR);
  assign rm_ex  = ex_regwrite && (ex_rd == id_rm) && (id_rm != XZR);
  assign rn_mem = mem_regwrite && (mem_rd == id_rn) && (id_rn != XZR);
  assign rm_mem = mem_regwrite && (mem_rd == id_rm) && (id_rm != XZR);

  assign load_use = ex_memread &&
                    ((id_use_rn && rn_ex) || (id_use_rm && rm_ex));
  // CBZ reads the regfile in ID with no bypass, so wait for WB
  assign cbz_stall = id_is_cbz && (rm_ex || rm_mem);
  assign stall     = load_use || cbz_stall;

  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = id_brtaken;
    if (reset) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end else if (stall) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b0;
    end
  end

  // Newest producer (EX) wins over MEM
  always_comb begin
    fwd_a_d = 2'd0;
    fwd_b_d = 2'd0;
    if (id_use_rn && rn_ex)       fwd_a_d = 2'd1;
    else if (id_use_rn && rn_mem) fwd_a_d = 2'd2;
    if (id_use_rm && rm_ex)       fwd_b_d = 2'd1;
    else if (id_use_rm && rm_mem) fwd_b_d = 2'd2;
  end

  assign live  = {ex_negativef, ex_overflowf, ex_zerof, ex_carryf};
  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;
  assign {flag_n, flag_v, flag_z, flag_c} =
    ex_flag_enable ? live : nzvc;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd          <= XZR;
      ex_regwrite    <= 1'b0;
      ex_memread     <= 1'b0;
      ex_flag_enable <= 1'b0;
      mem_rd         <= XZR;
      mem_regwrite   <= 1'b0;
      fwd_a_q        <= 2'd0;
      fwd_b_q        <= 2'd0;
      nzvc           <= 4'd0;
    end else begin
      mem_rd       <= ex_rd;
      mem_regwrite <= ex_regwrite;
      if (ex_flag_enable)
        nzvc <= live;
      if (stall) begin
        ex_rd          <= XZR;
        ex_regwrite    <= 1'b0;
        ex_memread     <= 1'b0;
        ex_flag_enable <= 1'b0;
        fwd_a_q        <= 2'd0;
        fwd_b_q        <= 2'd0;
      end else begin
        ex_rd          <= id_rd;
        ex_regwrite    <= id_regwrite;
        ex_memread     <= id_memread;
        ex_flag_enable <= id_flag_enable;
        fwd_a_q        <= fwd_a_d;
        fwd_b_q        <= fwd_b_d;
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: per-cycle expected
// control/forward/flag vectors queued and compared against samples.
module tb_hazard_control_unit;

  logic       clk;
  logic       reset;
  logic [4:0] id_rn, id_rm, id_rd;
  logic       id_use_rn, id_use_rm;
  logic       id_regwrite, id_memread, id_flag_enable;
  logic       id_is_cbz, id_brtaken;
  logic [3:0] ex_flags;
  logic       pc_we, ifid_we, ifid_flush, idex_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic       flag_n, flag_v, flag_z, flag_c;

  hazard_control_unit dut (
    .clk            (clk),
    .reset          (reset),
    .id_rn          (id_rn),
    .id_rm          (id_rm),
    .id_use_rn      (id_use_rn),
    .id_use_rm      (id_use_rm),
    .id_rd          (id_rd),
    .id_regwrite    (id_regwrite),
    .id_memread     (id_memread),
    .id_flag_enable (id_flag_enable),
    .id_is_cbz      (id_is_cbz),
    .id_brtaken     (id_brtaken),
    .ex_negativef   (ex_flags[3]),
    .ex_overflowf   (ex_flags[2]),
    .ex_zerof       (ex_flags[1]),
    .ex_carryf      (ex_flags[0]),
    .pc_we          (pc_we),
    .ifid_we        (ifid_we),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b),
    .flag_n         (flag_n),
    .flag_v         (flag_v),
    .flag_z         (flag_z),
    .flag_c         (flag_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pc_we, ifid_we, ifid_flush, idex_bubble}
  localparam logic [3:0] RUN  = 4'b1100;
  localparam logic [3:0] RUNF = 4'b1110;
  localparam logic [3:0] STL  = 4'b0001;
  localparam logic [3:0] RST  = 4'b0011;

  localparam logic [11:0] M_ALL = 12'hFFF;
  localparam logic [11:0] M_CF  = 12'hFF0;
  localparam logic [11:0] M_CTL = 12'hF00;
  localparam logic [11:0] M_CFL = 12'hF0F;

  int checks = 0;
  int failures = 0;

  logic [11:0] exp_q[$];
  logic [11:0] msk_q[$];
  logic [11:0] obs_q[$];
  string       tag_q[$];

  function automatic logic [11:0] mk(input logic [3:0] c,
                                     input logic [1:0] a,
                                     input logic [1:0] b,
                                     input logic [3:0] f);
    return {c, a, b, f};
  endfunction

  task automatic set_id(input logic [4:0] rn, input logic [4:0] rm,
                        input logic urn, input logic urm,
                        input logic [4:0] rd, input logic rw,
                        input logic mr, input logic fe,
                        input logic cbz, input logic br);
    id_rn = rn; id_rm = rm;
    id_use_rn = urn; id_use_rm = urm;
    id_rd = rd; id_regwrite = rw;
    id_memread = mr; id_flag_enable = fe;
    id_is_cbz = cbz; id_brtaken = br;
  endtask

  task automatic nop();
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called at a falling edge with inputs already driven
  task automatic step(input logic [11:0] e, input logic [11:0] m,
                      input string t);
    exp_q.push_back(e);
    msk_q.push_back(m);
    tag_q.push_back(t);
    #2;
    obs_q.push_back({pc_we, ifid_we, ifid_flush, idex_bubble,
                     fwd_a, fwd_b, flag_n, flag_v, flag_z, flag_c});
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [11:0] e, m, o;
    string t;
    reset = 1'b1;
    set_id(5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    ex_flags = 4'hF;
    step(mk(RST, 2'd0, 2'd0, 4'h0), M_ALL, "rst_ones_a");
    step(mk(RST, 2'd0, 2'd0, 4'h0), M_ALL, "rst_ones_b");
    reset = 1'b0;
    nop();
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_ALL, "post_rst");
    ex_flags = 4'h0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front();
      o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s got=%h want=%h mask=%h", t, o, e, m);
      end
    end
  endtask

  task automatic test_fwd();
    logic [11:0] e, m, o;
    string t;
    ex_flags = 4'h0;
    set_id(5'd2, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CF, "addi_x1");
    set_id(5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CF, "adds_in_id");
    nop(); ex_flags = 4'b0010;
    step(mk(RUN, 2'd1, 2'd1, 4'b0010), M_ALL, "fwd_ex");
    ex_flags = 4'h0;
    step(mk(RUN, 2'd0, 2'd0, 4'b0010), M_ALL, "flag_reg_hold");
    set_id(5'd2, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "addi_x1_b");
    set_id(5'd10, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "unrelated");
    set_id(5'd1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "adds_b_id");
    nop();
    step(mk(RUN, 2'd2, 2'd2, 4'h0), M_ALL, "fwd_mem");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front();
      o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s got=%h want=%h mask=%h", t, o, e, m);
      end
    end
  endtask

  task automatic test_load_use();
    logic [11:0] e, m, o;
    string t;
    ex_flags = 4'h0;
    set_id(5'd6, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "ldur_x3");
    set_id(5'd3, 5'd5, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(mk(STL, 2'd0, 2'd0, 4'h0), M_CTL, "lu_stall");
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CF, "lu_release");
    nop();
    step(mk(RUN, 2'd2, 2'd0, 4'h0), M_CF, "lu_fwd");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front();
      o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s got=%h want=%h mask=%h", t, o, e, m);
      end
    end
  endtask

  task automatic test_flags();
    logic [11:0] e, m, o;
    string t;
    ex_flags = 4'h0;
    set_id(5'd8, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "subs_id");
    set_id(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    ex_flags = 4'b1000;
    step(mk(RUNF, 2'd0, 2'd0, 4'b1000), M_CFL, "blt_bypass");
    set_id(5'd6, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ex_flags = 4'b0101;
    step(mk(RUN, 2'd0, 2'd0, 4'b1000), M_CFL, "nzvc_reg");
    set_id(5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ex_flags = 4'b0110;
    step(mk(STL, 2'd0, 2'd0, 4'b1000), M_CFL, "flags_in_stall");
    ex_flags = 4'b0111;
    step(mk(RUN, 2'd0, 2'd0, 4'b1000), M_CFL, "bubble_keeps");
    nop();
    step(mk(RUN, 2'd2, 2'd0, 4'b1000), M_ALL, "after_bubble");
    ex_flags = 4'h0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front();
      o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s got=%h want=%h mask=%h", t, o, e, m);
      end
    end
  endtask

  task automatic test_cbz();
    logic [11:0] e, m, o;
    string t;
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "addi_x7");
    set_id(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(mk(STL, 2'd0, 2'd0, 4'h0), M_CTL, "cbz_stall1");
    step(mk(STL, 2'd0, 2'd0, 4'h0), M_CTL, "cbz_stall2");
    step(mk(RUNF, 2'd0, 2'd0, 4'h0), M_CTL, "cbz_go");
    nop();
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "cbz_after");
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "ldur_x7");
    set_id(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(mk(STL, 2'd0, 2'd0, 4'h0), M_CTL, "cbz_ld_stall1");
    step(mk(STL, 2'd0, 2'd0, 4'h0), M_CTL, "cbz_ld_stall2");
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "cbz_ld_nt");
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "addi_x7_b");
    set_id(5'd10, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "gap");
    set_id(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(mk(STL, 2'd0, 2'd0, 4'h0), M_CTL, "cbz_mem_stall");
    step(mk(RUNF, 2'd0, 2'd0, 4'h0), M_CTL, "cbz_mem_go");
    nop();
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "cbz_mem_after");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front();
      o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s got=%h want=%h mask=%h", t, o, e, m);
      end
    end
  endtask

  task automatic test_xzr();
    logic [11:0] e, m, o;
    string t;
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "addi_xzr");
    set_id(5'd0, 5'd31, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(mk(RUNF, 2'd0, 2'd0, 4'h0), M_CTL, "cbz_xzr");
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "ldur_xzr");
    set_id(5'd31, 5'd31, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "lu_xzr_nostall");
    nop();
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CF, "xzr_nofwd");
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "ldur_x3");
    set_id(5'd3, 5'd3, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "unused_src");
    nop();
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CF, "unused_nofwd");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front();
      o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s got=%h want=%h mask=%h", t, o, e, m);
      end
    end
  endtask

  task automatic test_branch_stall();
    logic [11:0] e, m, o;
    string t;
    set_id(5'd6, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "br_ldur");
    set_id(5'd3, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(mk(STL, 2'd0, 2'd0, 4'h0), M_CTL, "br_held");
    step(mk(RUNF, 2'd0, 2'd0, 4'h0), M_CTL, "br_flush");
    nop();
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "br_once");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front();
      o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s got=%h want=%h mask=%h", t, o, e, m);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] e, m, o;
    string t;
    set_id(5'd2, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "b2b_i1");
    set_id(5'd1, 5'd0, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "b2b_i2");
    set_id(5'd1, 5'd1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd1, 2'd0, 4'h0), M_CF, "b2b_i2_fwd");
    set_id(5'd0, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd1, 2'd1, 4'h0), M_CF, "b2b_ex_prio");
    set_id(5'd6, 5'd5, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CF, "b2b_i4");
    nop();
    step(mk(RUN, 2'd1, 2'd2, 4'h0), M_CF, "b2b_mix");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front();
      o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s got=%h want=%h mask=%h", t, o, e, m);
      end
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [11:0] e, m, o;
    string t;
    ex_flags = 4'b1111;
    set_id(5'd6, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "mid_ldur");
    set_id(5'd3, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(mk(STL, 2'd0, 2'd0, 4'h0), M_CTL, "mid_stall");
    reset = 1'b1;
    step(mk(RST, 2'd0, 2'd0, 4'h0), M_CTL, "mid_reset");
    reset = 1'b0;
    step(mk(RUNF, 2'd0, 2'd0, 4'h0), M_ALL, "mid_empty");
    nop();
    step(mk(RUN, 2'd0, 2'd0, 4'h0), M_CTL, "mid_after");
    ex_flags = 4'h0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); m = msk_q.pop_front();
      o = obs_q.pop_front(); t = tag_q.pop_front();
      checks++;
      if ((o & m) !== (e & m)) begin
        failures++;
        $display("FAIL %s got=%h want=%h mask=%h", t, o, e, m);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ex_flags = 4'h0;
    nop();
    @(negedge clk);
    test_reset();
    test_fwd();
    test_load_use();
    test_flags();
    test_cbz();
    test_xzr();
    test_branch_stall();
    test_back_to_back();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
